frame_snapshot_buffer: RTL and testbench

Frame-coherent, multi-channel transfer buffer for game state crossing from the 60 Hz game-logic tick domain into the VGA pixel pipeline. The block runs entirely on main clock clk. It samples the game-side obstacle, player and gamemode bundle into a shadow bank once per game tick. It commits the shadow bank to the active (display) bank only on the start of vertical blanking, so a displayed frame never mixes two game states. It sits between game_logic/map and vga_screen_pic.

---
 rtl/frame_snapshot_buffer.sv | 162 ++++++++++++++++
 tb/tb_frame_snapshot_buffer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_snapshot_buffer.sv
// rtl/frame_snapshot_buffer.sv - frame-coherent shadow/active bank for game state entering the VGA pipeline
// Optional macro SNAP_DROP_CNT_EN enables the saturating drop counter; otherwise drop_cnt is tied to 0.
module frame_snapshot_buffer #(
    parameter int NUM_OBS      = 10,
    parameter int X_W          = 10,
    parameter int Y_W          = 9,
    parameter int MODE_W       = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int RST_X        = 700,
    parameter int RST_Y        = 500,
    parameter int RST_PLAYER_Y = 240
) (
    input  logic                     clk,
    input  logic                     rst_n_debounced,
    input  logic                     game_tick,
    input  logic                     vblank,
    input  logic [NUM_OBS*X_W-1:0]   obs_x_left_in,
    input  logic [NUM_OBS*X_W-1:0]   obs_x_right_in,
    input  logic [NUM_OBS*Y_W-1:0]   obs_y_up_in,
    input  logic [NUM_OBS*Y_W-1:0]   obs_y_down_in,
    input  logic [Y_W-1:0]           player_y_in,
    input  logic [MODE_W-1:0]        gamemode_in,
    output logic [NUM_OBS*X_W-1:0]   obs_x_left_out,
    output logic [NUM_OBS*X_W-1:0]   obs_x_right_out,
    output logic [NUM_OBS*Y_W-1:0]   obs_y_up_out,
    output logic [NUM_OBS*Y_W-1:0]   obs_y_down_out,
    output logic [Y_W-1:0]           player_y_out,
    output logic [MODE_W-1:0]        gamemode_out,
    output logic                     frame_commit,
    output logic                     snapshot_valid,
    output logic [7:0]               drop_cnt
);

    localparam int XB = NUM_OBS * X_W;
    localparam int YB = NUM_OBS * Y_W;
    localparam logic [X_W-1:0] RST_X_CH = X_W'(RST_X);
    localparam logic [Y_W-1:0] RST_Y_CH = Y_W'(RST_Y);
    localparam logic [XB-1:0]  RST_XB   = {NUM_OBS{RST_X_CH}};
    localparam logic [YB-1:0]  RST_YB   = {NUM_OBS{RST_Y_CH}};
    localparam logic [Y_W-1:0] RST_PY   = Y_W'(RST_PLAYER_Y);

    typedef enum logic {EMPTY, PENDING} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] tick_sync, vb_sync;
    logic                   tick_hist, vb_hist;
    logic [SYNC_STAGES:0]   fill;
    logic                   cap_evt, vb_evt;
    logic                   load_shadow, commit;

    logic [XB-1:0]     sh_xl, sh_xr;
    logic [YB-1:0]     sh_yu, sh_yd;
    logic [Y_W-1:0]    sh_py;
    logic [MODE_W-1:0] sh_gm;

    // fill marks when the history flops hold real samples, so a level already
    // high at reset release is not mistaken for an edge
    always_ff @(posedge clk or negedge rst_n_debounced) begin
        if (!rst_n_debounced) begin
            tick_sync <= '0;
            vb_sync   <= '0;
            tick_hist <= 1'b0;
            vb_hist   <= 1'b0;
            fill      <= '0;
        end else begin
            tick_sync <= {tick_sync[SYNC_STAGES-2:0], game_tick};
            vb_sync   <= {vb_sync[SYNC_STAGES-2:0], vblank};
            tick_hist <= tick_sync[SYNC_STAGES-1];
            vb_hist   <= vb_sync[SYNC_STAGES-1];
            fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign cap_evt = fill[SYNC_STAGES] & tick_hist & ~tick_sync[SYNC_STAGES-1];
    assign vb_evt  = fill[SYNC_STAGES] & ~vb_hist & vb_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n_debounced) begin
        if (!rst_n_debounced) state <= EMPTY;
        else                  state <= state_next;
    end

    always_comb begin
        state_next  = state;
        load_shadow = 1'b0;
        commit      = 1'b0;
        case (state)
            EMPTY: begin
                if (cap_evt) begin
                    load_shadow = 1'b1;
                    state_next  = PENDING;
                end
            end
            PENDING: begin
                load_shadow = cap_evt;
                commit      = vb_evt;
                if (vb_evt && !cap_evt) state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_debounced) begin
        if (!rst_n_debounced) begin
            sh_xl <= RST_XB;
            sh_xr <= RST_XB;
            sh_yu <= RST_YB;
            sh_yd <= RST_YB;
            sh_py <= RST_PY;
            sh_gm <= '0;
        end else if (load_shadow) begin
            sh_xl <= obs_x_left_in;
            sh_xr <= obs_x_right_in;
            sh_yu <= obs_y_up_in;
            sh_yd <= obs_y_down_in;
            sh_py <= player_y_in;
            sh_gm <= gamemode_in;
        end
    end

    // active bank takes the pre-edge shadow, so a coincident capture lands next frame
    always_ff @(posedge clk or negedge rst_n_debounced) begin
        if (!rst_n_debounced) begin
            obs_x_left_out  <= RST_XB;
            obs_x_right_out <= RST_XB;
            obs_y_up_out    <= RST_YB;
            obs_y_down_out  <= RST_YB;
            player_y_out    <= RST_PY;
            gamemode_out    <= '0;
            frame_commit    <= 1'b0;
            snapshot_valid  <= 1'b0;
        end else begin
            frame_commit <= commit;
            if (commit) begin
                obs_x_left_out  <= sh_xl;
                obs_x_right_out <= sh_xr;
                obs_y_up_out    <= sh_yu;
                obs_y_down_out  <= sh_yd;
                player_y_out    <= sh_py;
                gamemode_out    <= sh_gm;
                snapshot_valid  <= 1'b1;
            end
        end
    end

`ifdef SNAP_DROP_CNT_EN
    logic       drop_inc;
    logic [7:0] drop_q;

    assign drop_inc = (state == PENDING) & cap_evt & ~vb_evt;

    always_ff @(posedge clk or negedge rst_n_debounced) begin
        if (!rst_n_debounced)                 drop_q <= 8'd0;
        else if (drop_inc && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_frame_snapshot_buffer.sv
// tb/tb_frame_snapshot_buffer.sv - directed self-checking bench for frame_snapshot_buffer
module tb_frame_snapshot_buffer;

    localparam int XB = 100;
    localparam int YB = 90;
    localparam logic [XB-1:0] RXB = {10{10'd700}};
    localparam logic [YB-1:0] RYB = {10{9'd500}};
`ifdef SNAP_DROP_CNT_EN
    localparam logic [7:0] DROP1 = 8'd1;
`else
    localparam logic [7:0] DROP1 = 8'd0;
`endif

    logic          clk = 1'b0;
    logic          rst_n_debounced = 1'b0;
    logic          game_tick = 1'b0;
    logic          vblank = 1'b0;
    logic [XB-1:0] obs_x_left_in, obs_x_right_in;
    logic [YB-1:0] obs_y_up_in, obs_y_down_in;
    logic [8:0]    player_y_in;
    logic [1:0]    gamemode_in;
    logic [XB-1:0] obs_x_left_out, obs_x_right_out;
    logic [YB-1:0] obs_y_up_out, obs_y_down_out;
    logic [8:0]    player_y_out;
    logic [1:0]    gamemode_out;
    logic          frame_commit, snapshot_valid;
    logic [7:0]    drop_cnt;

    int total = 0;
    int bad = 0;

    logic [XB-1:0] base_xl, base_xr;
    logic [YB-1:0] base_yu, base_yd;

    frame_snapshot_buffer dut (
        .clk(clk), .rst_n_debounced(rst_n_debounced),
        .game_tick(game_tick), .vblank(vblank),
        .obs_x_left_in(obs_x_left_in), .obs_x_right_in(obs_x_right_in),
        .obs_y_up_in(obs_y_up_in), .obs_y_down_in(obs_y_down_in),
        .player_y_in(player_y_in), .gamemode_in(gamemode_in),
        .obs_x_left_out(obs_x_left_out), .obs_x_right_out(obs_x_right_out),
        .obs_y_up_out(obs_y_up_out), .obs_y_down_out(obs_y_down_out),
        .player_y_out(player_y_out), .gamemode_out(gamemode_out),
        .frame_commit(frame_commit), .snapshot_valid(snapshot_valid),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick_pulse(input logic [8:0] py);
        player_y_in = py;
        @(posedge clk); #2 game_tick = 1'b1;
        repeat (6) @(posedge clk);
        #2 game_tick = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic count_commits(output int n, output int first);
        n = 0;
        first = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (frame_commit) begin
                n++;
                if (first < 0) first = i;
            end
        end
    endtask

    task automatic vblank_pulse(output int n, output int first);
        @(posedge clk); #2 vblank = 1'b1;
        count_commits(n, first);
        vblank = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int n, f;
        repeat (3) @(posedge clk);
        #1;
        total++; if (obs_x_left_out !== RXB || obs_x_right_out !== RXB) begin bad++; $display("FAIL rst_x got %h/%h want %h", obs_x_left_out, obs_x_right_out, RXB); end
        total++; if (obs_y_up_out !== RYB || obs_y_down_out !== RYB) begin bad++; $display("FAIL rst_y got %h/%h want %h", obs_y_up_out, obs_y_down_out, RYB); end
        total++; if (player_y_out !== 9'd240) begin bad++; $display("FAIL rst_py got %0d want 240", player_y_out); end
        total++; if (gamemode_out !== 2'd0 || snapshot_valid !== 1'b0 || frame_commit !== 1'b0) begin bad++; $display("FAIL rst_flags got gm=%0d v=%b fc=%b want 0/0/0", gamemode_out, snapshot_valid, frame_commit); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL rst_drop got %0d want 0", drop_cnt); end
        @(posedge clk); #2 rst_n_debounced = 1'b1;
        repeat (5) @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            vblank_pulse(n, f);
            total++; if (n != 0) begin bad++; $display("FAIL rst_vb_commit[%0d] got %0d want 0", k, n); end
        end
        total++; if (player_y_out !== 9'd240 || snapshot_valid !== 1'b0 || obs_x_left_out !== RXB) begin bad++; $display("FAIL rst_vb_hold got py=%0d v=%b want 240/0", player_y_out, snapshot_valid); end
    endtask

    task automatic test_basic;
        int n, f;
        gamemode_in = 2'd1;
        obs_x_left_in[30 +: 10] = 10'd320;
        base_xl = obs_x_left_in;
        tick_pulse(9'd100);
        total++; if (player_y_out !== 9'd240 || snapshot_valid !== 1'b0) begin bad++; $display("FAIL basic_precommit got py=%0d v=%b want 240/0", player_y_out, snapshot_valid); end
        vblank_pulse(n, f);
        total++; if (n != 1 || f != 3) begin bad++; $display("FAIL basic_pulse got n=%0d at=%0d want n=1 at=3", n, f); end
        total++; if (player_y_out !== 9'd100 || gamemode_out !== 2'd1) begin bad++; $display("FAIL basic_py_gm got %0d/%0d want 100/1", player_y_out, gamemode_out); end
        total++; if (obs_x_left_out[30 +: 10] !== 10'd320 || obs_x_left_out !== base_xl) begin bad++; $display("FAIL basic_xl got %0d want 320", obs_x_left_out[30 +: 10]); end
        total++; if (obs_x_right_out !== base_xr || obs_y_up_out !== base_yu || obs_y_down_out !== base_yd) begin bad++; $display("FAIL basic_buses got %h want %h", obs_x_right_out, base_xr); end
        total++; if (snapshot_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got %b want 1", snapshot_valid); end
    endtask

    task automatic test_overwrite;
        int n, f;
        tick_pulse(9'd50);
        tick_pulse(9'd60);
        total++; if (player_y_out !== 9'd100) begin bad++; $display("FAIL ovw_hold got %0d want 100", player_y_out); end
        vblank_pulse(n, f);
        total++; if (n != 1 || player_y_out !== 9'd60) begin bad++; $display("FAIL ovw_py got n=%0d py=%0d want 1/60", n, player_y_out); end
        total++; if (drop_cnt !== DROP1) begin bad++; $display("FAIL ovw_drop got %0d want %0d", drop_cnt, DROP1); end
    endtask

    task automatic test_coincident;
        int n, f;
        tick_pulse(9'd70);
        player_y_in = 9'd80;
        @(posedge clk); #2 game_tick = 1'b1;
        repeat (6) @(posedge clk);
        #2 game_tick = 1'b0; vblank = 1'b1;
        count_commits(n, f);
        vblank = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        total++; if (n != 1 || f != 3) begin bad++; $display("FAIL coin_pulse got n=%0d at=%0d want 1 at 3", n, f); end
        total++; if (player_y_out !== 9'd70) begin bad++; $display("FAIL coin_old got %0d want 70", player_y_out); end
        vblank_pulse(n, f);
        total++; if (n != 1 || player_y_out !== 9'd80) begin bad++; $display("FAIL coin_next got n=%0d py=%0d want 1/80", n, player_y_out); end
        total++; if (drop_cnt !== DROP1) begin bad++; $display("FAIL coin_drop got %0d want %0d", drop_cnt, DROP1); end
        vblank_pulse(n, f);
        total++; if (n != 0) begin bad++; $display("FAIL coin_empty_vb got %0d want 0", n); end
    endtask

    task automatic test_midframe;
        int errs = 0;
        logic [127:0] r;
        tick_pulse(9'd33);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            r = {$urandom, $urandom, $urandom, $urandom};
            obs_x_left_in  = r[99:0];
            obs_x_right_in = r[127:28];
            r = {$urandom, $urandom, $urandom, $urandom};
            obs_y_up_in   = r[89:0];
            obs_y_down_in = r[127:38];
            player_y_in   = r[8:0];
            gamemode_in   = r[10:9];
            @(posedge clk); #1;
            if (player_y_out !== 9'd80 || gamemode_out !== 2'd1 || obs_x_left_out !== base_xl ||
                obs_x_right_out !== base_xr || obs_y_up_out !== base_yu || obs_y_down_out !== base_yd ||
                frame_commit !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL midframe_stable got %0d changed cycles want 0", errs); end
    endtask

    task automatic test_reset_pending;
        int n, f;
        tick_pulse(9'd90);
        @(posedge clk); #2 rst_n_debounced = 1'b0;
        #1;
        total++; if (player_y_out !== 9'd240 || obs_x_left_out !== RXB || snapshot_valid !== 1'b0) begin bad++; $display("FAIL rstp_async got py=%0d v=%b want 240/0", player_y_out, snapshot_valid); end
        total++; if (drop_cnt !== 8'd0 || gamemode_out !== 2'd0) begin bad++; $display("FAIL rstp_drop got %0d/%0d want 0/0", drop_cnt, gamemode_out); end
        repeat (3) @(posedge clk);
        #2 rst_n_debounced = 1'b1;
        repeat (5) @(posedge clk);
        vblank_pulse(n, f);
        total++; if (n != 0) begin bad++; $display("FAIL rstp_commit got %0d want 0", n); end
        total++; if (player_y_out !== 9'd240 || snapshot_valid !== 1'b0) begin bad++; $display("FAIL rstp_py got %0d want 240", player_y_out); end
    endtask

    initial begin
        base_xl = {10{10'd123}};
        base_xr = {10{10'd456}};
        base_yu = {10{9'd111}};
        base_yd = {10{9'd222}};
        obs_x_left_in  = base_xl;
        obs_x_right_in = base_xr;
        obs_y_up_in    = base_yu;
        obs_y_down_in  = base_yd;
        player_y_in    = 9'd0;
        gamemode_in    = 2'd0;
        test_reset;
        test_basic;
        test_overwrite;
        test_coincident;
        test_midframe;
        test_reset_pending;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
